// File: rtl/gpu_pkg.sv
// gpu_pkg: shared byte-enable constants, pixel request struct and write-path state encoding
package gpu_pkg;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;
   localparam int MAX_COORD_W = 16;
   typedef struct packed {
      logic [MAX_COORD_W-1:0] x;
      logic [MAX_COORD_W-1:0] y;
      logic [15:0]            color;
   } pixel_req_t;
   // encoding is {avm_write, hv} so the state can be read straight off the registers
   typedef enum logic [1:0] {
      EMPTY        = 2'b00,
      HELD         = 2'b01,
      WRITING      = 2'b10,
      WRITING_HELD = 2'b11
   } wr_state_t;
endpackage

// File: rtl/pixel_addr_calc.sv
// pixel_addr_calc: frame-buffer word address and half-word select for a pixel
module pixel_addr_calc
   import gpu_pkg::*;
#(
   parameter int SCREEN_WIDTH = 640
) (
   input  logic [MAX_COORD_W-1:0] x,
   input  logic [MAX_COORD_W-1:0] y,
   input  logic [31:0]            base_addr,
   output logic [31:0]            word,
   output logic                   half
);
   logic [31:0] idx;
   assign idx  = 32'(y) * 32'(SCREEN_WIDTH) + 32'(x);
   assign word = (base_addr + (idx << 1)) & ~32'd3;
   assign half = idx[0];
endmodule

// File: rtl/pixel_write_ctrl.sv
// pixel_write_ctrl: merges adjacent pixel writes into 32-bit words and drives an Avalon-MM write master
module pixel_write_ctrl
   import gpu_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int COORD_W       = 10,
   parameter int HOLD_CYCLES   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        base_addr,
   input  logic               px_valid,
   output logic               px_ready,
   input  logic [COORD_W-1:0] px_x,
   input  logic [COORD_W-1:0] px_y,
   input  logic [15:0]        px_color,
   input  logic               flush,
   output logic               busy,
   output logic [15:0]        clip_count,
   output logic [31:0]        avm_address,
   output logic               avm_write,
   output logic [31:0]        avm_writedata,
   output logic [3:0]         avm_byteenable,
   input  logic               avm_waitrequest
);
   localparam int TW = $clog2(HOLD_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(HOLD_CYCLES - 1);
   pixel_req_t req;
   wr_state_t state;
   logic hv, h_half, half;
   logic [31:0] h_word, word, out_data;
   logic [15:0] h_color;
   logic [TW-1:0] timer;
   logic accept, in_range, take, same, merge, spill, expire, load_out;
   assign req = '{x: MAX_COORD_W'(px_x), y: MAX_COORD_W'(px_y), color: px_color};
   assign state = wr_state_t'({avm_write, hv});
   assign px_ready = !flush && state != WRITING_HELD;
   assign busy = state != EMPTY;
   pixel_addr_calc #(.SCREEN_WIDTH(SCREEN_WIDTH)) u_addr (
      .x(req.x), .y(req.y), .base_addr(base_addr), .word(word), .half(half)
   );
   always_comb begin
      accept   = px_valid && px_ready;
      in_range = req.x < MAX_COORD_W'(SCREEN_WIDTH) && req.y < MAX_COORD_W'(SCREEN_HEIGHT);
      take     = accept && in_range;
      same     = hv && word == h_word;
      merge    = take && same && half != h_half;
      spill    = take && hv && !same;
      expire   = hv && !accept && (timer >= T_LAST || flush) && !avm_write;
      load_out = merge || spill || expire;
      out_data = merge ? (h_half ? {h_color, req.color} : {req.color, h_color}) : {h_color, h_color};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
         hv             <= 1'b0;
         h_word         <= '0;
         h_half         <= 1'b0;
         h_color        <= '0;
         timer          <= '0;
         clip_count     <= '0;
      end else begin
         if (load_out) begin
            avm_write      <= 1'b1;
            avm_address    <= h_word;
            avm_writedata  <= out_data;
            avm_byteenable <= merge ? BE_ALL : (h_half ? BE_HI : BE_LO);
         end else if (avm_write && !avm_waitrequest) begin
            avm_write <= 1'b0;
         end
         // a merge consumes the held pixel; any other in-range accept (re)fills the hold
         hv <= take ? !merge : (expire ? 1'b0 : hv);
         if (take && !merge) begin
            h_word  <= word;
            h_half  <= half;
            h_color <= req.color;
            timer   <= '0;
         end else if (hv && !accept) begin
            timer <= timer >= T_LAST ? timer : timer + 1'b1;
         end
         if (accept && !in_range && clip_count != 16'hFFFF)
            clip_count <= clip_count + 1'b1;
      end
   end
endmodule

// File: doc/pixel_write_ctrl.md
# pixel_write_ctrl

Pixel write sequencer between the rasterizer and the frame-buffer Avalon-MM master port. Accepts (x, y, color) pixel requests over a valid/ready handshake and computes the word-aligned frame-buffer address. Merges two horizontally adjacent pixels that share a 32-bit word into one full-word write. Issues writes with replicated color data and half-word byte enables, and holds each write until `avm_waitrequest` is low.

## Interface
- SCREEN_WIDTH, 640: pixels per row.
- SCREEN_HEIGHT, 480: rows.
- COORD_W, 10: x/y coordinate width.
- HOLD_CYCLES, 4: idle cycles a lone held pixel waits for its partner (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous and active-high. The block has one clock.
- base_addr  in  32  frame-buffer byte base address, word-aligned; sampled when a pixel is accepted.
- px_valid  in  1  pixel request valid.
- px_ready  out  1  pixel request ready.
- px_x, px_y  in  COORD_W  pixel coordinates.
- px_color  in  16  RGB565 color.
- flush  in  1  level-sensitive drain request.
- busy  out  1  hold register or output register occupied.
- clip_count  out  16  saturating count of discarded out-of-range pixels.
- avm_address  out  32  byte address, bits [1:0] = 0.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  byte enables.
- avm_waitrequest  in  1  slave stall.

## Operation
- Address math:
  - idx = y*SCREEN_WIDTH + x.
  - Byte address = base_addr + (idx<<1).
  - Word address = byte address & ~3.
  - half = idx[0].
- Single write:
  - writedata = {color,color}.
  - byteenable = 0011 when half=0, 1100 when half=1.
- Merged write:
  - writedata = {odd_color, even_color}.
  - byteenable = 1111.
- Storage: hold register (hv, word, half, color, timer) and output register (drives avm_*).
- States (from hv, avm_write): EMPTY, HELD, WRITING, WRITING_HELD.
- px_ready = !flush && (!hv || !avm_write). It is derived from registered state only; there is no combinational path from avm_waitrequest.
- Out-of-range pixel (x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT):
  - Accepted and discarded.
  - clip_count increments, saturating at 0xFFFF.
  - Hold register is untouched.
- Accepted in-range pixel, hold empty: load the hold register, timer=0.
- Accepted pixel, hold valid:
  - Same word, opposite half: merged write goes into the output register; hold clears.
  - Same word, same half: replace the held color (later pixel wins); timer=0.
  - Different word: held pixel goes into the output register as a single write; new pixel enters the hold register with timer=0.
- Hold valid, no accept:
  - timer increments.
  - When timer ≥ HOLD_CYCLES-1, or flush=1, and the output register is free (!avm_write), emit a single write and clear the hold.
- Output register:
  - avm_* stay stable while avm_write=1 and avm_waitrequest=1.
  - On a cycle with avm_write=1 and avm_waitrequest=0, the write completes and avm_write clears.
  - A new load is possible only on a later cycle (one-cycle bubble).
- Flush: blocks input; busy falls once hold and output are both empty. Flush while idle has no effect.
- busy = hv || avm_write.

## Timing
- Reset values:
  - avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
  - hv=0, timer=0, clip_count=0.
  - Therefore px_ready=1 and busy=0 in the cycle after reset.
- Reset mid-write: avm_write is 0 after the reset edge; the in-flight write and the held pixel are abandoned.
- Merge latency: pixel accepted at edge 0, partner accepted at edge 1, avm_write=1 after edge 1.
- Lone pixel: accepted at edge 0 with the output register free; avm_write=1 after edge HOLD_CYCLES.
- Different-word handoff: the new pixel is accepted in the same edge the held pixel moves to the output register.
- Back-to-back writes with waitrequest=0: one write per 2 cycles.

## Structure
- Shared package gpu_pkg holds:
  - BE_LO=4'b0011, BE_HI=4'b1100, BE_ALL=4'b1111.
  - The pixel request struct (x, y, color).
  - The state enum.
- Sub-module pixel_addr_calc: combinational idx/word/half computation from x, y, base_addr. SCREEN_WIDTH is a parameter.

## Test plan
All scenarios use base_addr=0x1000_0000 and default parameters.
- Merge: (2,0,0xF800) then (3,0,0x07E0) on consecutive cycles → one write: addr 0x1000_0004, data 0x07E0F800, be 1111.
- Lone pixel: (5,1,0x1234), then idle → after 4 cycles one write: addr 0x1000_0508, data 0x12341234, be 1100.
- Stall: (0,0,0xAAAA), then (10,0,0xBBBB), with avm_waitrequest=1 for 3 cycles:
  - Write addr 0x1000_0000, be 0011, held stable 4 cycles.
  - px_ready=0 while WRITING_HELD.
  - Then write addr 0x1000_0014, be 0011.
- Clip: (640,0) and (0,480) → no avm_write, clip_count=2. clip_count saturates at 0xFFFF after a forced long run.
- Same-half overwrite plus flush: (4,2,0x1111) then (4,2,0x2222), flush=1 →
  - One write: data 0x22222222, be 0011.
  - px_ready=0 while flush=1.
  - busy=0 after completion.
- Reset mid-write: reset asserted during a stalled write → next cycle avm_write=0, busy=0, clip_count=0, px_ready=1.
